// File: rtl/frame_disp_pkg.sv
// ============================================================================
// Module   : frame_disp_pkg
// Purpose  : Shared types and constants for the frame nibble display path:
//            display FSM state encoding, blank segment pattern and the
//            hex-to-7-segment lookup.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package frame_disp_pkg;

   // Display sequencer states
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SHOW = 2'd1,
      GAP  = 2'd2
   } state_t;

   // All segments off (active-high polarity)
   localparam logic [6:0] SEG_BLANK = 7'h00;

   // Hex digit to segments {g,f,e,d,c,b,a}, active high
   function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
      logic [6:0] seg;
      case (nib)
         4'h0:    seg = 7'h3F;
         4'h1:    seg = 7'h06;
         4'h2:    seg = 7'h5B;
         4'h3:    seg = 7'h4F;
         4'h4:    seg = 7'h66;
         4'h5:    seg = 7'h6D;
         4'h6:    seg = 7'h7D;
         4'h7:    seg = 7'h07;
         4'h8:    seg = 7'h7F;
         4'h9:    seg = 7'h6F;
         4'hA:    seg = 7'h77;
         4'hB:    seg = 7'h7C;
         4'hC:    seg = 7'h39;
         4'hD:    seg = 7'h5E;
         4'hE:    seg = 7'h79;
         default: seg = 7'h71;
      endcase
      return seg;
   endfunction

endpackage

`default_nettype wire

// File: rtl/hex7seg_decode.sv
// ============================================================================
// Module   : hex7seg_decode
// Purpose  : Combinational 4-bit hex digit to 7-segment decoder, active-high
//            segments {g,f,e,d,c,b,a}. Usable by any display path.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module hex7seg_decode
   import frame_disp_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [6:0] seg
);

   // Pure table lookup, no state
   always_comb begin
      seg = hex_to_seg(nibble);
   end

endmodule

`default_nettype wire

// File: rtl/frame_nibble_display.sv
// ============================================================================
// Module   : frame_nibble_display
// Purpose  : Shows a captured FRAME_W-bit frame as hex digits on a 7-segment
//            display, nibble 0 first, each digit held TICK_COUNT cycles,
//            followed by a blank gap and a one-cycle done pulse. A frame
//            arriving while busy is parked in a one-deep, last-wins slot.
// Options  : SEG_ACTIVE_LOW_EN - invert seg_out and dp at the pins.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module frame_nibble_display
   import frame_disp_pkg::*;
#(
   parameter logic [23:0] TICK_COUNT = 24'd10_000_000,
   parameter int          FRAME_W    = 64
)(
   input  logic               clk,
   input  logic               rst_n,
   input  logic [FRAME_W-1:0] frame_in,
   input  logic               frame_valid,
   input  logic               hold,
   output logic [6:0]         seg_out,
   output logic               dp,
   output logic               busy,
   output logic [3:0]         nib_idx,
   output logic               done
);

   localparam int          NIB_COUNT = FRAME_W / 4;
   localparam logic [3:0]  NIB_LAST  = 4'(NIB_COUNT - 1);
   // A zero period behaves like a period of one cycle
   localparam logic [23:0] TICK_LAST = (TICK_COUNT == 24'd0) ? 24'd0 : (TICK_COUNT - 24'd1);

   state_t             r_state,     w_state;
   logic [FRAME_W-1:0] r_shadow,    w_shadow;
   logic [FRAME_W-1:0] r_pending,   w_pending;
   logic               r_pending_v, w_pending_v;
   logic [23:0]        r_tick,      w_tick;
   logic [3:0]         r_nib_idx,   w_nib_idx;
   logic               r_done,      w_done;

   logic               w_tick_wrap;
   logic [5:0]         w_bit_base;
   logic [3:0]         w_nibble;
   logic [6:0]         w_dec_seg;
   logic [6:0]         w_seg_hi;
   logic               w_dp_hi;

   // State and datapath registers; reset aborts any frame and drops the pending slot
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_shadow    <= '0;
         r_pending   <= '0;
         r_pending_v <= 1'b0;
         r_tick      <= 24'd0;
         r_nib_idx   <= 4'd0;
         r_done      <= 1'b0;
      end else begin
         r_state     <= w_state;
         r_shadow    <= w_shadow;
         r_pending   <= w_pending;
         r_pending_v <= w_pending_v;
         r_tick      <= w_tick;
         r_nib_idx   <= w_nib_idx;
         r_done      <= w_done;
      end
   end

   // Next-state logic: tick pacing, nibble stepping, pending slot and frame hand-off
   always_comb begin
      w_state     = r_state;
      w_shadow    = r_shadow;
      w_pending   = r_pending;
      w_pending_v = r_pending_v;
      w_tick      = r_tick;
      w_nib_idx   = r_nib_idx;
      w_done      = 1'b0;
      w_tick_wrap = (r_tick == TICK_LAST);

      case (r_state)
         IDLE: begin
            if (frame_valid) begin
               w_shadow  = frame_in;
               w_nib_idx = 4'd0;
               w_tick    = 24'd0;
               w_state   = SHOW;
            end
         end

         SHOW: begin
            if (frame_valid) begin
               w_pending   = frame_in;
               w_pending_v = 1'b1;
            end
            if (!hold) begin
               if (w_tick_wrap) begin
                  w_tick = 24'd0;
                  if (r_nib_idx == NIB_LAST) begin
                     w_state = GAP;
                  end else begin
                     w_nib_idx = r_nib_idx + 4'd1;
                  end
               end else begin
                  w_tick = r_tick + 24'd1;
               end
            end
         end

         GAP: begin
            if (frame_valid) begin
               w_pending   = frame_in;
               w_pending_v = 1'b1;
            end
            if (!hold) begin
               if (w_tick_wrap) begin
                  w_tick    = 24'd0;
                  w_done    = 1'b1;
                  w_nib_idx = 4'd0;
                  // A strobe landing on the wrap itself beats any older pending frame
                  if (frame_valid) begin
                     w_shadow    = frame_in;
                     w_pending_v = 1'b0;
                     w_state     = SHOW;
                  end else if (r_pending_v) begin
                     w_shadow    = r_pending;
                     w_pending_v = 1'b0;
                     w_state     = SHOW;
                  end else begin
                     w_state = IDLE;
                  end
               end else begin
                  w_tick = r_tick + 24'd1;
               end
            end
         end

         default: begin
            w_state = IDLE;
         end
      endcase
   end

   // Select the displayed nibble straight from registers
   assign w_bit_base = {r_nib_idx, 2'b00};
   assign w_nibble   = r_shadow[w_bit_base +: 4];

   hex7seg_decode u_hex7seg_decode (
      .nibble (w_nibble),
      .seg    (w_dec_seg)
   );

   // Active-high display image: digits only while showing, dp marks nibble 0
   always_comb begin
      w_seg_hi = SEG_BLANK;
      w_dp_hi  = 1'b0;
      if (r_state == SHOW) begin
         w_seg_hi = w_dec_seg;
         w_dp_hi  = (r_nib_idx == 4'd0);
      end
   end

`ifdef SEG_ACTIVE_LOW_EN
   assign seg_out = ~w_seg_hi;
   assign dp      = ~w_dp_hi;
`else
   assign seg_out = w_seg_hi;
   assign dp      = w_dp_hi;
`endif

   assign busy    = (r_state != IDLE);
   assign nib_idx = r_nib_idx;
   assign done    = r_done;

endmodule

`default_nettype wire

// File: tb/tb_frame_nibble_display.sv
// ============================================================================
// Module   : tb_frame_nibble_display
// Purpose  : Directed self-checking bench for frame_nibble_display with
//            TICK_COUNT=4 (one digit = 4 cycles, one frame = 68 cycles).
//            Honours SEG_ACTIVE_LOW_EN when defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_frame_nibble_display;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [63:0] frame_in;
   logic        frame_valid;
   logic        hold;
   logic [6:0]  seg_out;
   logic        dp;
   logic        busy;
   logic [3:0]  nib_idx;
   logic        done;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   frame_nibble_display #(
      .TICK_COUNT (24'd4),
      .FRAME_W    (64)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .frame_in    (frame_in),
      .frame_valid (frame_valid),
      .hold        (hold),
      .seg_out     (seg_out),
      .dp          (dp),
      .busy        (busy),
      .nib_idx     (nib_idx),
      .done        (done)
   );

   // Hand-entered segment table, polarity applied at the end
   function automatic logic [6:0] seg_of(input logic [3:0] n);
      logic [6:0] s;
      case (n)
         4'h0: s = 7'h3F;  4'h1: s = 7'h06;  4'h2: s = 7'h5B;  4'h3: s = 7'h4F;
         4'h4: s = 7'h66;  4'h5: s = 7'h6D;  4'h6: s = 7'h7D;  4'h7: s = 7'h07;
         4'h8: s = 7'h7F;  4'h9: s = 7'h6F;  4'hA: s = 7'h77;  4'hB: s = 7'h7C;
         4'hC: s = 7'h39;  4'hD: s = 7'h5E;  4'hE: s = 7'h79;  default: s = 7'h71;
      endcase
`ifdef SEG_ACTIVE_LOW_EN
      return ~s;
`else
      return s;
`endif
   endfunction

   function automatic logic [6:0] blank_seg();
`ifdef SEG_ACTIVE_LOW_EN
      return 7'h7F;
`else
      return 7'h00;
`endif
   endfunction

   function automatic logic dp_of(input logic on);
`ifdef SEG_ACTIVE_LOW_EN
      return ~on;
`else
      return on;
`endif
   endfunction

   // Expected {seg, dp, busy} at local cycle k (0..67) of a displayed frame
   function automatic logic [8:0] exp_show(input logic [63:0] f, input int k);
      logic [3:0] n;
      if (k < 64) begin
         n = f[(k/4)*4 +: 4];
         return {seg_of(n), dp_of(k < 4), 1'b1};
      end
      return {blank_seg(), dp_of(1'b0), 1'b1};
   endfunction

   task automatic test_reset();
      rst_n = 1'b0; frame_in = '0; frame_valid = 1'b0; hold = 1'b0;
      #1;
      n_cmp++;
      if ({seg_out, dp, busy, nib_idx, done} !== {blank_seg(), dp_of(1'b0), 1'b0, 4'd0, 1'b0}) begin
         n_bad++;
         $display("FAIL reset_state got seg=%h dp=%b busy=%b idx=%0d done=%b want seg=%h dp=%b busy=0 idx=0 done=0",
                  seg_out, dp, busy, nib_idx, done, blank_seg(), dp_of(1'b0));
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_single_frame();
      logic [63:0] f;
      logic [9:0]  e;
      f = 64'h0123_4567_89AB_CDEF;
      @(negedge clk); frame_in = f; frame_valid = 1'b1;
      @(negedge clk); frame_valid = 1'b0;
      n_cmp++;
      if ({seg_out, dp} !== {seg_of(4'hF), dp_of(1'b1)}) begin
         n_bad++;
         $display("FAIL first_digit got seg=%h dp=%b want seg=%h dp=%b", seg_out, dp, seg_of(4'hF), dp_of(1'b1));
      end
      for (int c = 0; c < 70; c++) begin
         e = (c < 68) ? {exp_show(f, c), 1'b0} : {blank_seg(), dp_of(1'b0), 1'b0, (c == 68)};
         n_cmp++;
         if ({seg_out, dp, busy, done} !== e || (c < 64 && nib_idx !== 4'(c/4))) begin
            n_bad++;
            $display("FAIL single_frame c=%0d got {seg,dp,busy,done}=%h idx=%0d want %h idx=%0d",
                     c, {seg_out, dp, busy, done}, nib_idx, e, c/4);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_hold();
      logic [63:0] f;
      logic [9:0]  e;
      int          k;
      f = 64'h0123_4567_89AB_CDEF;
      @(negedge clk); frame_in = f; frame_valid = 1'b1;
      @(negedge clk); frame_valid = 1'b0;
      for (int c = 0; c < 80; c++) begin
         k = (c < 14) ? c : (c < 24) ? 13 : c - 10;
         e = (k < 68) ? {exp_show(f, k), 1'b0} : {blank_seg(), dp_of(1'b0), 1'b0, (k == 68)};
         n_cmp++;
         if ({seg_out, dp, busy, done} !== e || (k < 64 && nib_idx !== 4'(k/4))) begin
            n_bad++;
            $display("FAIL hold c=%0d got {seg,dp,busy,done}=%h idx=%0d want %h idx=%0d",
                     c, {seg_out, dp, busy, done}, nib_idx, e, k/4);
         end
         if (c == 13) hold = 1'b1;
         if (c == 23) hold = 1'b0;
         @(negedge clk);
      end
   endtask

   task automatic test_back_to_back();
      logic [63:0] f1, f2, cur;
      logic [9:0]  e;
      int          k;
      f1 = 64'h0123_4567_89AB_CDEF;
      f2 = 64'hFFFF_FFFF_FFFF_FFFF;
      @(negedge clk); frame_in = f1; frame_valid = 1'b1;
      @(negedge clk); frame_valid = 1'b0;
      for (int c = 0; c < 138; c++) begin
         k   = (c < 68) ? c : c - 68;
         cur = (c < 68) ? f1 : f2;
         e = (k < 68) ? {exp_show(cur, k), (c == 68)} : {blank_seg(), dp_of(1'b0), 1'b0, (k == 68)};
         n_cmp++;
         if ({seg_out, dp, busy, done} !== e || (k < 64 && nib_idx !== 4'(k/4))) begin
            n_bad++;
            $display("FAIL back_to_back c=%0d got {seg,dp,busy,done}=%h idx=%0d want %h idx=%0d",
                     c, {seg_out, dp, busy, done}, nib_idx, e, k/4);
         end
         if (c == 20) begin frame_in = f2; frame_valid = 1'b1; end
         if (c == 21) frame_valid = 1'b0;
         @(negedge clk);
      end
   endtask

   task automatic test_last_wins();
      logic [63:0] f1, fa, fb, cur;
      logic [9:0]  e;
      int          k;
      f1 = 64'h2222_2222_2222_2222;
      fa = 64'h1111_1111_1111_1111;
      fb = 64'h0123_4567_89AB_CDEF;
      @(negedge clk); frame_in = f1; frame_valid = 1'b1;
      @(negedge clk); frame_valid = 1'b0;
      for (int c = 0; c < 138; c++) begin
         k   = (c < 68) ? c : c - 68;
         cur = (c < 68) ? f1 : fb;
         e = (k < 68) ? {exp_show(cur, k), (c == 68)} : {blank_seg(), dp_of(1'b0), 1'b0, (k == 68)};
         n_cmp++;
         if ({seg_out, dp, busy, done} !== e || (k < 64 && nib_idx !== 4'(k/4))) begin
            n_bad++;
            $display("FAIL last_wins c=%0d got {seg,dp,busy,done}=%h idx=%0d want %h idx=%0d",
                     c, {seg_out, dp, busy, done}, nib_idx, e, k/4);
         end
         if (c == 10) begin frame_in = fa; frame_valid = 1'b1; end
         if (c == 11) frame_valid = 1'b0;
         if (c == 30) begin frame_in = fb; frame_valid = 1'b1; end
         if (c == 31) frame_valid = 1'b0;
         @(negedge clk);
      end
   endtask

   task automatic test_gap_wrap_strobe();
      logic [63:0] f1, f2, cur;
      logic [9:0]  e;
      int          k;
      f1 = 64'h3333_3333_3333_3333;
      f2 = 64'hDCBA_9876_5432_10EA;
      @(negedge clk); frame_in = f1; frame_valid = 1'b1;
      @(negedge clk); frame_valid = 1'b0;
      for (int c = 0; c < 138; c++) begin
         k   = (c < 68) ? c : c - 68;
         cur = (c < 68) ? f1 : f2;
         e = (k < 68) ? {exp_show(cur, k), (c == 68)} : {blank_seg(), dp_of(1'b0), 1'b0, (k == 68)};
         n_cmp++;
         if ({seg_out, dp, busy, done} !== e || (k < 64 && nib_idx !== 4'(k/4))) begin
            n_bad++;
            $display("FAIL gap_wrap_strobe c=%0d got {seg,dp,busy,done}=%h idx=%0d want %h idx=%0d",
                     c, {seg_out, dp, busy, done}, nib_idx, e, k/4);
         end
         if (c == 67) begin frame_in = f2; frame_valid = 1'b1; end
         if (c == 68) frame_valid = 1'b0;
         @(negedge clk);
      end
   endtask

   task automatic test_reset_mid_show();
      logic [63:0] f;
      int          done_cnt;
      int          busy_cnt;
      f = 64'h0123_4567_89AB_CDEF;
      @(negedge clk); frame_in = f; frame_valid = 1'b1;
      @(negedge clk); frame_valid = 1'b0;
      for (int c = 0; c < 20; c++) begin
         // Park a frame in the pending slot; reset must discard it
         if (c == 5) begin frame_in = 64'hAAAA_AAAA_AAAA_AAAA; frame_valid = 1'b1; end
         if (c == 6) frame_valid = 1'b0;
         @(negedge clk);
      end
      n_cmp++;
      if (nib_idx !== 4'd5 || seg_out !== seg_of(4'hA)) begin
         n_bad++;
         $display("FAIL pre_reset_nibble got idx=%0d seg=%h want idx=5 seg=%h", nib_idx, seg_out, seg_of(4'hA));
      end
      #2 rst_n = 1'b0;
      #1;
      n_cmp++;
      if ({seg_out, dp, busy, nib_idx, done} !== {blank_seg(), dp_of(1'b0), 1'b0, 4'd0, 1'b0}) begin
         n_bad++;
         $display("FAIL reset_mid_show got seg=%h dp=%b busy=%b idx=%0d done=%b want seg=%h dp=%b busy=0 idx=0 done=0",
                  seg_out, dp, busy, nib_idx, done, blank_seg(), dp_of(1'b0));
      end
      @(negedge clk);
      rst_n = 1'b1;
      done_cnt = 0;
      busy_cnt = 0;
      for (int c = 0; c < 100; c++) begin
         @(negedge clk);
         if (done === 1'b1) done_cnt++;
         if (busy !== 1'b0) busy_cnt++;
      end
      n_cmp++;
      if (done_cnt != 0 || busy_cnt != 0) begin
         n_bad++;
         $display("FAIL post_reset_idle got done_pulses=%0d busy_cycles=%0d want 0 and 0", done_cnt, busy_cnt);
      end
   endtask

   initial begin
      test_reset();
      test_single_frame();
      test_hold();
      test_back_to_back();
      test_last_wins();
      test_gap_wrap_strobe();
      test_reset_mid_show();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

`default_nettype wire
